// File: rtl/row_buffer_multi_pkg.sv
// Shared conv-datapath definitions: standard row lengths, beat type and a
// width helper used to size counters from depths.
package row_buffer_multi_pkg;

    // Row lengths after removing 2 pixels of padding from 320/80/40/20/10
    localparam int unsigned LEN_320 = 318;
    localparam int unsigned LEN_80  = 78;
    localparam int unsigned LEN_40  = 38;
    localparam int unsigned LEN_20  = 18;
    localparam int unsigned LEN_10  = 8;

    localparam int unsigned BEAT_DW = 8;
    localparam int unsigned BEAT_CH = 2;

    typedef logic [BEAT_CH*BEAT_DW-1:0] beat_t;

    // Bits needed to index 'depth' entries (minimum 1)
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/row_buffer_multi_mem.sv
// One row of delay storage: async read, sync write, read-old-data at the
// shared address; no reset so it can map to distributed or vendor RAM.
module row_delay_mem #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/row_buffer_multi.sv
// Multi-row line buffer: presents a column of ROWS+1 pixels per channel for
// every accepted beat, with runtime row length and a priming flag.
module row_buffer_multi
    import row_buffer_multi_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned CH      = 2,
    parameter int unsigned ROWS    = 2,
    parameter int unsigned MAX_LEN = 512,
    parameter int unsigned AW      = 9,
    parameter int unsigned DEF_LEN = LEN_320
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [AW-1:0]              len_cfg,
    input  logic                       len_load,
    input  logic                       din_valid,
    input  logic [CH*DW-1:0]           din,
    output logic                       dout_valid,
    output logic [(ROWS+1)*CH*DW-1:0]  dout,
    output logic                       rows_ready,
    output logic [AW-1:0]              col_idx
);

    localparam int unsigned BW = CH * DW;
    localparam int unsigned OW = (ROWS + 1) * BW;
    localparam int unsigned LW = addr_width(MAX_LEN + 1);
    localparam int unsigned FW = addr_width(ROWS * MAX_LEN + 1);

    logic [AW-1:0]            ptr;
    logic [FW-1:0]            fill;
    logic [LW-1:0]            len_q;

    logic                     accept_c;
    logic                     ptr_last_c;
    logic [LW-1:0]            len_cfg_c;
    logic [FW-1:0]            fill_target_c;
    logic [FW-1:0]            fill_inc_c;
    logic [ROWS-1:0][BW-1:0]  row_rd;

    // A reconfiguration strobe wins over a simultaneous input beat
    assign accept_c      = din_valid & ~len_load;
    assign ptr_last_c    = (32'(ptr) == 32'(len_q) - 32'd1);
    assign len_cfg_c     = (len_cfg == '0 || 32'(len_cfg) > MAX_LEN) ? LW'(MAX_LEN)
                                                                     : LW'(len_cfg);
    assign fill_target_c = FW'(ROWS) * FW'(len_q);
    assign fill_inc_c    = fill + FW'(1);

    // Row r is fed by row r-1's old contents, forming a shift chain per column
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [BW-1:0] wdata;
        if (r == 0) begin : g_head
            assign wdata = din;
        end else begin : g_tail
            assign wdata = row_rd[r-1];
        end

        row_delay_mem #(
            .W     (BW),
            .DEPTH (MAX_LEN),
            .AW    (AW)
        ) u_mem (
            .clk   (clk),
            .we    (accept_c),
            .addr  (ptr),
            .wdata (wdata),
            .rdata (row_rd[r])
        );
    end

    // Pointer, fill counter, length and registered output column
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            fill       <= '0;
            len_q      <= LW'(DEF_LEN);
            rows_ready <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            col_idx    <= '0;
        end else if (len_load) begin
            ptr        <= '0;
            fill       <= '0;
            len_q      <= len_cfg_c;
            rows_ready <= 1'b0;
            dout_valid <= 1'b0;
        end else if (din_valid) begin
            ptr        <= ptr_last_c ? '0 : ptr + AW'(1);
            if (fill < fill_target_c) fill <= fill_inc_c;
            rows_ready <= rows_ready | (fill_inc_c >= fill_target_c);
            dout_valid <= 1'b1;
            dout       <= OW'({row_rd, din});
            col_idx    <= ptr;
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_row_buffer_multi.sv
// Directed bench for row_buffer_multi at DW=8, CH=2, ROWS=2, MAX_LEN=512.
module tb_row_buffer_multi;
    import row_buffer_multi_pkg::*;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] len_cfg = '0;
    logic          len_load = 1'b0;
    logic          din_valid = 1'b0;
    beat_t         din = '0;
    logic          dout_valid;
    logic [47:0]   dout;
    logic          rows_ready;
    logic [AW-1:0] col_idx;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t hist [0:1023];
    beat_t d;
    logic [47:0] held;

    row_buffer_multi dut (
        .clk        (clk),
        .rstn       (rstn),
        .len_cfg    (len_cfg),
        .len_load   (len_load),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .rows_ready (rows_ready),
        .col_idx    (col_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, step past the edge, release strobes
    task automatic cyc(input logic v, input beat_t dd, input logic ld, input logic [AW-1:0] lc);
        din_valid = v;
        din       = dd;
        len_load  = ld;
        len_cfg   = lc;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        len_load  = 1'b0;
    endtask

    function automatic beat_t tap(input logic [47:0] x, input int r);
        return x[r*16 +: 16];
    endfunction

    initial begin
        // Test 1: reset held while din_valid toggles
        for (int i = 0; i < 4; i++) begin
            cyc(1'(i % 2), 16'hABCD, 1'b0, '0);
            check("rst_dout_valid", 64'(dout_valid), 64'd0);
            check("rst_rows_ready", 64'(rows_ready), 64'd0);
            check("rst_col_idx",    64'(col_idx),    64'd0);
            check("rst_dout",       64'(dout),       64'd0);
        end
        rstn = 1'b1;
        cyc(1'b0, '0, 1'b0, '0);
        // Default length 318: column wraps after 317
        for (int k = 0; k < 319; k++) begin
            cyc(1'b1, beat_t'(k), 1'b0, '0);
            if (k == 317) check("def_col_317", 64'(col_idx), 64'd317);
            if (k == 318) begin
                check("def_col_wrap", 64'(col_idx),    64'd0);
                check("def_not_rdy",  64'(rows_ready), 64'd0);
                check("def_tap0",     64'(tap(dout, 0)), 64'(16'd318));
            end
        end

        // Test 2: basic delay with length 4
        cyc(1'b0, '0, 1'b1, 9'd4);
        check("t2_load_valid", 64'(dout_valid), 64'd0);
        check("t2_load_rdy",   64'(rows_ready), 64'd0);
        for (int k = 0; k < 12; k++) begin
            d = {8'(k), 8'(k + 100)};
            hist[k] = d;
            cyc(1'b1, d, 1'b0, '0);
            check($sformatf("t2_valid k=%0d", k), 64'(dout_valid), 64'd1);
            check($sformatf("t2_col k=%0d", k),   64'(col_idx), 64'(k % 4));
            check($sformatf("t2_rdy k=%0d", k),   64'(rows_ready), 64'(k >= 7));
            check($sformatf("t2_tap0 k=%0d", k),  64'(tap(dout, 0)), 64'(d));
            if (k == 8) check("t2_k8_dout", 64'(dout), 64'h0064_0468_086C);
            if (k >= 8) begin
                check($sformatf("t2_tap1 k=%0d", k), 64'(tap(dout, 1)), 64'(hist[k-4]));
                check($sformatf("t2_tap2 k=%0d", k), 64'(tap(dout, 2)), 64'(hist[k-8]));
            end
        end
        held = {hist[3], hist[7], hist[11]};
        cyc(1'b0, '0, 1'b0, '0);
        check("t2_idle_valid", 64'(dout_valid), 64'd0);
        check("t2_idle_hold",  64'(dout), 64'(held));

        // Test 3: same stream with random idle gaps
        cyc(1'b0, '0, 1'b1, 9'd4);
        for (int k = 0; k < 12; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 16'hFFFF, 1'b0, '0);
                check($sformatf("t3_gap k=%0d", k), 64'(dout_valid), 64'd0);
            end
            d = {8'(k), 8'(k + 100)};
            cyc(1'b1, d, 1'b0, '0);
            check($sformatf("t3_valid k=%0d", k), 64'(dout_valid), 64'd1);
            check($sformatf("t3_col k=%0d", k),   64'(col_idx), 64'(k % 4));
            check($sformatf("t3_rdy k=%0d", k),   64'(rows_ready), 64'(k >= 7));
            if (k == 8) check("t3_k8_dout", 64'(dout), 64'h0064_0468_086C);
            if (k >= 8) check($sformatf("t3_tap2 k=%0d", k), 64'(tap(dout, 2)), 64'(hist[k-8]));
        end

        // Test 4: wrap over 20 beats
        cyc(1'b0, '0, 1'b1, 9'd4);
        for (int k = 0; k < 20; k++) begin
            d = {8'(k * 3), 8'(k) ^ 8'h5A};
            hist[k] = d;
            cyc(1'b1, d, 1'b0, '0);
            check($sformatf("t4_col k=%0d", k), 64'(col_idx), 64'(k % 4));
            if (k >= 8) check($sformatf("t4_tap2 k=%0d", k), 64'(tap(dout, 2)), 64'(hist[k-8]));
        end

        // Test 5: len_load wins over a simultaneous beat
        check("t5_primed", 64'(rows_ready), 64'd1);
        cyc(1'b1, 16'hDEAD, 1'b1, 9'd10);
        check("t5_drop_valid", 64'(dout_valid), 64'd0);
        check("t5_drop_rdy",   64'(rows_ready), 64'd0);
        for (int k = 0; k < 20; k++) begin
            d = {8'(k + 50), 8'(k + 200)};
            hist[k] = d;
            cyc(1'b1, d, 1'b0, '0);
            check($sformatf("t5_col k=%0d", k), 64'(col_idx), 64'(k % 10));
            check($sformatf("t5_rdy k=%0d", k), 64'(rows_ready), 64'(k >= 19));
            if (k >= 10) check($sformatf("t5_tap1 k=%0d", k), 64'(tap(dout, 1)), 64'(hist[k-10]));
        end

        // Test 6: zero length clamps to 512
        cyc(1'b0, '0, 1'b1, 9'd0);
        for (int k = 0; k < 1024; k++) begin
            d = beat_t'(k * 7 + 1);
            hist[k] = d;
            cyc(1'b1, d, 1'b0, '0);
            if (k == 511) check("t6_col_511", 64'(col_idx), 64'd511);
            if (k == 512) begin
                check("t6_col_wrap", 64'(col_idx), 64'd0);
                check("t6_tap1_512", 64'(tap(dout, 1)), 64'(hist[0]));
            end
            if (k == 1022) check("t6_rdy_1022", 64'(rows_ready), 64'd0);
            if (k == 1023) begin
                check("t6_rdy_1023",  64'(rows_ready), 64'd1);
                check("t6_tap1_1023", 64'(tap(dout, 1)), 64'(hist[511]));
            end
        end

        // Asynchronous reset mid-stream
        din_valid = 1'b1;
        din       = 16'h1234;
        @(posedge clk);
        #2;
        check("t6_pre_valid", 64'(dout_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("t6_arst_valid", 64'(dout_valid), 64'd0);
        check("t6_arst_rdy",   64'(rows_ready), 64'd0);
        check("t6_arst_col",   64'(col_idx),    64'd0);
        check("t6_arst_dout",  64'(dout),       64'd0);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b0, '0, 1'b0, '0);
        check("t6_post_valid", 64'(dout_valid), 64'd0);
        check("t6_post_dout",  64'(dout),       64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
